corner_sb_tile_cfg: RTL
=======================

# corner_sb_tile_cfg

Parametrised bottom-left corner switch-box tile with a double-buffered configuration chain. Configuration bits shift in serially on `prog_clk` and are applied to the routing fabric only on an explicit, length-checked commit, so routing never glitches during reprogramming. It sits at fabric position (0,0). It routes the top channel and pads onto the right channel, and the right channel and pads onto the top channel. It is a member of the configuration-chain daisy chain.

## Interface
Parameters:
- `CHAN_W`, default 30: tracks per channel direction.
- `NUM_PADS`, default 4: inpad subtiles per neighbouring I/O grid.
- `CFG_BITS`, derived as 4*CHAN_W: routing select bits.

Ports:
- `prog_clk`, in, 1: single clock.
- `prog_reset`, in, 1: synchronous, active-low reset.
- `ccff_head`, in, 1: serial configuration input.
- `ccff_en`, in, 1: shift enable.
- `ccff_commit`, in, 1: one-cycle commit strobe.
- `chanx_right_in`, in, CHAN_W: right channel inputs.
- `chany_top_in`, in, CHAN_W: top channel inputs.
- `top_left_pad`, in, NUM_PADS: top-left grid inpads.
- `right_bottom_pad`, in, NUM_PADS: right-bottom grid inpads.
- `ccff_tail`, out, 1: serial configuration output to the next tile.
- `chanx_right_out`, out, CHAN_W: routed right channel.
- `chany_top_out`, out, CHAN_W: routed top channel.
- `cfg_valid`, out, 1: a committed configuration is active.
- `cfg_err`, out, 1: last commit was rejected (sticky).

## Operation
- Chain length: LEN = CFG_BITS, or CFG_BITS+1 when parity is enabled.
- Shift register `sr[LEN-1:0]`. When `ccff_en` is high: `sr <= {sr[LEN-2:0], ccff_head}`.
- `ccff_tail` = `sr[LEN-1]`. It is a register output, with no combinational path from `ccff_head`.
- Bit counter `cnt` increments on each shift and saturates at LEN+1. The overflow value marks an over-length load.
- Commit logic: when `ccff_commit` is high and `ccff_en` is low:
  - If `cnt == LEN` (and parity passes, see Configuration): copy the config bits to `cfg_q`, set `cfg_valid`=1, clear `cfg_err`, clear `cnt`.
  - Otherwise: set `cfg_err`=1. `cfg_q` and `cfg_valid` are unchanged. Clear `cnt`.
- `ccff_commit` and `ccff_en` high in the same cycle: the shift happens and `cnt` increments; the commit is rejected with `cfg_err`=1 and `cnt` is not cleared.
- State machine, two states:
  - UNCFG, entered at reset: all routed outputs are driven to 0.
  - ACTIVE: entered on the first accepted commit. Leaves only through reset.
  - A rejected commit while ACTIVE keeps the previous routing.
- Config mapping: `cfg_q` equals `sr[LEN-1 -: CFG_BITS]`, so the first bit shifted in lands at the MSB.
  - `sel = cfg_q[2i+1:2i]` drives `chanx_right_out[i]`.
  - `cfg_q[2CHAN_W+2i+1 : 2CHAN_W+2i]` drives `chany_top_out[i]`.
- Select encoding for `chanx_right_out[i]`:
  - 0: `chany_top_in[i]`
  - 1: `chany_top_in[(i+1) % CHAN_W]`
  - 2: `top_left_pad[i % NUM_PADS]`
  - 3: `right_bottom_pad[i % NUM_PADS]`
- `chany_top_out[i]` uses the same encoding, with `chanx_right_in` substituted for `chany_top_in`.
- Index wrap-around uses compile-time modulo; there are no runtime bounds cases.

## Timing
- Reset values: `sr`=0, `cnt`=0, `cfg_q`=0, `ccff_tail`=0, `cfg_valid`=0, `cfg_err`=0, routed outputs 0.
- Reset asserted mid-shift or mid-commit wins over every other action in that cycle.
- `ccff_head` to `ccff_tail` latency: LEN enabled shift cycles.
- A commit sampled at edge N gives new routing and `cfg_valid` from cycle N+1.
- Routing from channel or pad inputs to the outputs is purely combinational through `cfg_q`.
- Shifting never disturbs `cfg_q`. Outputs stay stable throughout a reload.

## Configuration
- Macro: `CCFF_PARITY_EN`.
- Defined:
  - LEN = CFG_BITS+1.
  - The final bit shifted in, `sr[0]`, is an even-parity bit over the CFG_BITS config bits.
  - A commit is accepted only if `cnt == LEN` and XOR(`sr`) == 0. A parity failure sets `cfg_err`.
- Undefined:
  - LEN = CFG_BITS.
  - No parity check is performed.

## Structure
- Package `fpga_tile_pkg` holds:
  - SEL_W = 2.
  - Select encoding constants: SEL_STRAIGHT, SEL_NEXT, SEL_PAD_TL, SEL_PAD_RB.
  - The state enum (UNCFG, ACTIVE).
- Sub-module `sb_route_mux4`: a 4:1 combinational mux with a 2-bit select. It is instantiated 2*CHAN_W times through a generate loop.
- The chain, counter, commit logic and FSM live in the top module.

## Test plan
All scenarios use CHAN_W=30, NUM_PADS=4, parity disabled unless noted.
- Reset, then drive `chany_top_in`=all-ones -> `chanx_right_out`=0, `cfg_valid`=0, `ccff_tail`=0.
- Shift 120 zero bits, then commit -> `cfg_valid`=1 next cycle and `chanx_right_out` equals `chany_top_in`. With `chanx_right_in`=30'h155 -> `chany_top_out`=30'h155.
- Load sel=3 for all tracks with `right_bottom_pad`=4'b0101 -> `chanx_right_out[i]` = bit i%4 of 4'b0101, i.e. 30'h1555_5555.
- Shift 119 bits, then commit -> `cfg_err`=1 and routing unchanged. Shift 121 bits, then commit -> `cfg_err`=1.
- Simultaneous `ccff_en` and `ccff_commit` at cnt=119 -> commit rejected, `cnt`=120. A following lone commit is accepted.
- With `CCFF_PARITY_EN`: 121 bits with a corrupted parity bit -> `cfg_err`=1 and previous routing retained. With correct parity -> accepted. `ccff_tail` reproduces `ccff_head` delayed by 121 shift cycles.

Source files
------------

// File: rtl/fpga_tile_pkg.sv
// Shared definitions for switch-box tiles: route-select encoding and the
// configuration state enum.
package fpga_tile_pkg;

  localparam int SEL_W = 2;

  // Route-select encoding used by every switch-box output mux
  localparam logic [SEL_W-1:0] SEL_STRAIGHT = 2'd0;  // same-index track
  localparam logic [SEL_W-1:0] SEL_NEXT     = 2'd1;  // next track, wrapping
  localparam logic [SEL_W-1:0] SEL_PAD_TL   = 2'd2;  // top-left grid inpad
  localparam logic [SEL_W-1:0] SEL_PAD_RB   = 2'd3;  // right-bottom grid inpad

  typedef enum logic {
    UNCFG  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/sb_route_mux4.sv
// 4:1 routing mux; input order follows the select encoding in fpga_tile_pkg.
module sb_route_mux4
  import fpga_tile_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic [3:0]       in,
  output logic             out
);

  // Pick one of the four candidate sources
  always_comb begin
    out = in[0];
    case (sel)
      SEL_STRAIGHT: out = in[0];
      SEL_NEXT:     out = in[1];
      SEL_PAD_TL:   out = in[2];
      SEL_PAD_RB:   out = in[3];
      default:      out = in[0];
    endcase
  end

endmodule

// File: rtl/corner_sb_tile_cfg.sv
// Bottom-left corner switch box with a double-buffered configuration chain.
// Bits shift serially into sr; routing only changes on an accepted,
// length-checked commit that copies sr into cfg_q.
// Optional feature: define CCFF_PARITY_EN to append an even-parity bit to
// the chain and require it to check out before a commit is accepted.
module corner_sb_tile_cfg
  import fpga_tile_pkg::*;
#(
  parameter int CHAN_W   = 30,
  parameter int NUM_PADS = 4
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_commit,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  input  logic [CHAN_W-1:0]   chany_top_in,
  input  logic [NUM_PADS-1:0] top_left_pad,
  input  logic [NUM_PADS-1:0] right_bottom_pad,
  output logic                ccff_tail,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int CFG_BITS = 4 * CHAN_W;
`ifdef CCFF_PARITY_EN
  localparam int LEN = CFG_BITS + 1;
`else
  localparam int LEN = CFG_BITS;
`endif
  // Counter must reach LEN+1, which flags an over-length load
  localparam int CNT_W = $clog2(LEN + 2);

  logic [LEN-1:0]      sr;
  logic [CNT_W-1:0]    cnt;
  logic [CFG_BITS-1:0] cfg_q;
  logic                parity_ok;
  logic                commit_ok;
  logic                route_en;
  state_t              state_reg;
  state_t              state_next;
  logic [CHAN_W-1:0]   mux_x;
  logic [CHAN_W-1:0]   mux_y;

`ifdef CCFF_PARITY_EN
  assign parity_ok = ~(^sr);
`else
  assign parity_ok = 1'b1;
`endif

  // A commit counts only as a lone strobe on an exactly full chain
  assign commit_ok = ccff_commit & ~ccff_en & (cnt == CNT_W'(LEN)) & parity_ok;
  assign ccff_tail = sr[LEN-1];

  // Serial shift chain; the MSB feeds the next tile
  always_ff @(posedge prog_clk) begin
    if (!prog_reset)  sr <= '0;
    else if (ccff_en) sr <= {sr[LEN-2:0], ccff_head};
  end

  // Shift counter: saturating increment, cleared by a lone commit strobe
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      cnt <= '0;
    end else if (ccff_en) begin
      if (cnt != CNT_W'(LEN + 1)) cnt <= cnt + CNT_W'(1);
    end else if (ccff_commit) begin
      cnt <= '0;
    end
  end

  // Shadow config register and sticky error flag updated on commit
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      cfg_q   <= '0;
      cfg_err <= 1'b0;
    end else if (commit_ok) begin
      cfg_q   <= sr[LEN-1 -: CFG_BITS];
      cfg_err <= 1'b0;
    end else if (ccff_commit) begin
      cfg_err <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) state_reg <= UNCFG;
    else             state_reg <= state_next;
  end

  // FSM next state: the first accepted commit activates routing for good
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      UNCFG:   if (commit_ok) state_next = ACTIVE;
      ACTIVE:  state_next = ACTIVE;
      default: state_next = UNCFG;
    endcase
  end

  // FSM outputs: routed channels are held at zero until configured
  always_comb begin
    route_en        = (state_reg == ACTIVE);
    cfg_valid       = route_en;
    chanx_right_out = route_en ? mux_x : '0;
    chany_top_out   = route_en ? mux_y : '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHAN_W; gi++) begin : g_route
      sb_route_mux4 u_mux_x (
        .sel (cfg_q[2*gi +: SEL_W]),
        .in  ({right_bottom_pad[gi % NUM_PADS], top_left_pad[gi % NUM_PADS],
               chany_top_in[(gi + 1) % CHAN_W], chany_top_in[gi]}),
        .out (mux_x[gi])
      );
      sb_route_mux4 u_mux_y (
        .sel (cfg_q[2*CHAN_W + 2*gi +: SEL_W]),
        .in  ({right_bottom_pad[gi % NUM_PADS], top_left_pad[gi % NUM_PADS],
               chanx_right_in[(gi + 1) % CHAN_W], chanx_right_in[gi]}),
        .out (mux_y[gi])
      );
    end
  endgenerate

endmodule
